// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C master arbiter and its round-robin picker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2c_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  localparam int I2C_ADDR_W       = 7;
  localparam int I2C_DATA_W       = 8;
  localparam int WDOG_CYCLES_DFLT = 2000000;

endpackage

// File: rtl/i2c_rr_picker.sv
// Round-robin picker: first set req[k] searching k = ptr, ptr+1, ... modulo N.
// Latency: combinational.
// Backpressure: none; valid is simply |req.
// Ports: req (request vector), ptr (search start index, must be < N),
//        winner (selected index), valid (any request present).
module i2c_rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest match to ptr wins.
  // The wrap is a single subtraction, so a non-power-of-2 N never yields an
  // index >= N.
  always_comb begin
    winner = '0;
    valid  = |req;
    idx    = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx[IDX_W-1:0]]) winner = idx[IDX_W-1:0];
    end
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one i2c_master between NUM_REQ requesters with round-robin arbitration.
// Latency: req sampled in cycle t -> gnt/m_start in t+1; done pulses the cycle after m_busy is seen low.
// Backpressure: losers hold req until granted; m_start is held until m_busy is sampled high.
// Ports: clk/reset (sync, active-high); req/req_addr/req_rw/req_wdata per-requester command;
//        gnt/done/err/rdata per-requester response; busy = not IDLE;
//        m_start/m_addr/m_rw/m_wdata/m_busy/m_rdata = i2c_master handshake.
// Optional watchdog: define I2C_ARB_WDOG_EN to abort a transaction after WDOG_CYCLES
// in LAUNCH+WAIT with an err pulse; otherwise err stays 0 and the wait is unbounded.
module i2c_master_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WDOG_CYCLES = WDOG_CYCLES_DFLT
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*I2C_ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ-1:0]               req_rw,
  input  logic [NUM_REQ*I2C_DATA_W-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               done,
  output logic [NUM_REQ-1:0]               err,
  output logic [NUM_REQ*I2C_DATA_W-1:0]    rdata,
  output logic                             busy,
  output logic                             m_start,
  output logic [I2C_ADDR_W-1:0]            m_addr,
  output logic                             m_rw,
  output logic [I2C_DATA_W-1:0]            m_wdata,
  input  logic                             m_busy,
  input  logic [I2C_DATA_W-1:0]            m_rdata
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_CYCLES < 1) begin : g_param_check
    $error("i2c_master_arbiter: NUM_REQ must be 2..8 and WDOG_CYCLES >= 1");
  end

  arb_state_t            state;
  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      win;
  logic [IDX_W-1:0]      ptr_nxt;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_vld;
  logic                  wdog_hit;

  logic [I2C_ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [I2C_DATA_W-1:0] wdata_arr [NUM_REQ];
  logic [I2C_DATA_W-1:0] rdata_q   [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign addr_arr[g]  = req_addr[g*I2C_ADDR_W +: I2C_ADDR_W];
    assign wdata_arr[g] = req_wdata[g*I2C_DATA_W +: I2C_DATA_W];
    assign rdata[g*I2C_DATA_W +: I2C_DATA_W] = rdata_q[g];
  end

  i2c_rr_picker #(.N(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_idx),
    .valid  (pick_vld)
  );

  // Explicit wrap keeps ptr inside 0..NUM_REQ-1 for any NUM_REQ.
  assign ptr_nxt = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;

`ifdef I2C_ARB_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wdog_cnt;

  // Cleared while IDLE, so every LAUNCH entry starts from zero.
  always_ff @(posedge clk) begin
    if (reset || state == IDLE) begin
      wdog_cnt <= '0;
    end else if (state == LAUNCH || state == WAIT) begin
      wdog_cnt <= wdog_cnt + 1'b1;
    end
  end

  // Fires on the WDOG_CYCLES-th cycle spent in LAUNCH+WAIT.
  assign wdog_hit = (state == LAUNCH || state == WAIT) &&
                    (wdog_cnt == WD_W'(WDOG_CYCLES - 1));
`else
  // No watchdog: the abort path below is unreachable and err stays 0.
  assign wdog_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      win     <= '0;
      gnt     <= '0;
      done    <= '0;
      err     <= '0;
      busy    <= 1'b0;
      m_start <= 1'b0;
      m_addr  <= '0;
      m_rw    <= 1'b0;
      m_wdata <= '0;
      for (int i = 0; i < NUM_REQ; i++) rdata_q[i] <= '0;
    end else begin
      done <= '0;
      err  <= '0;
      if (wdog_hit) begin
        err[win] <= 1'b1;
        gnt      <= '0;
        m_start  <= 1'b0;
        ptr      <= ptr_nxt;
        busy     <= 1'b0;
        state    <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (pick_vld) begin
              // Snapshot the winner's command; later input changes are ignored.
              win           <= pick_idx;
              gnt[pick_idx] <= 1'b1;
              m_addr        <= addr_arr[pick_idx];
              m_rw          <= req_rw[pick_idx];
              m_wdata       <= wdata_arr[pick_idx];
              m_start       <= 1'b1;
              busy          <= 1'b1;
              state         <= LAUNCH;
            end
          end
          LAUNCH: begin
            if (m_busy) begin
              m_start <= 1'b0;
              state   <= WAIT;
            end
          end
          WAIT: begin
            // Completion outputs are registered here so they are visible during DONE.
            if (!m_busy) begin
              done[win] <= 1'b1;
              if (m_rw) rdata_q[win] <= m_rdata;
              gnt   <= '0;
              ptr   <= ptr_nxt;
              state <= DONE;
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
module tb_i2c_master_arbiter;
  import i2c_arb_pkg::*;

  localparam int NUM_REQ = 4;
`ifdef I2C_ARB_WDOG_EN
  localparam int WDOG_T = 50;
`else
  localparam int WDOG_T = WDOG_CYCLES_DFLT;
`endif

  logic                  clk;
  logic                  reset;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*7-1:0]  req_addr;
  logic [NUM_REQ-1:0]    req_rw;
  logic [NUM_REQ*8-1:0]  req_wdata;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    done;
  logic [NUM_REQ-1:0]    err;
  logic [NUM_REQ*8-1:0]  rdata;
  logic                  busy;
  logic                  m_start;
  logic [6:0]            m_addr;
  logic                  m_rw;
  logic [7:0]            m_wdata;
  logic                  m_busy;
  logic [7:0]            m_rdata;

  logic [6:0] tb_addr  [NUM_REQ];
  logic [7:0] tb_wdata [NUM_REQ];
  logic [7:0] rd_v     [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_tb_slice
    assign req_addr[g*7 +: 7]  = tb_addr[g];
    assign req_wdata[g*8 +: 8] = tb_wdata[g];
    assign rd_v[g]             = rdata[g*8 +: 8];
  end

  i2c_master_arbiter #(.NUM_REQ(NUM_REQ), .WDOG_CYCLES(WDOG_T)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_addr  (req_addr),
    .req_rw    (req_rw),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .busy      (busy),
    .m_start   (m_start),
    .m_addr    (m_addr),
    .m_rw      (m_rw),
    .m_wdata   (m_wdata),
    .m_busy    (m_busy),
    .m_rdata   (m_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  // One expected completion per transaction, in grant order.
  typedef struct {
    int         idx;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    logic [7:0] rbyte;
    logic       abort;
  } exp_t;

  exp_t       exp_q   [$];
  logic [7:0] slave_q [$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         ptr_m    = 0;
  logic       slave_hold = 1'b0;
  int         round_cnt [NUM_REQ];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Behavioural i2c_master: goes busy 1..3 cycles after seeing m_start, stays
  // busy 1..5 cycles (or while slave_hold), then returns the next queued byte.
  initial begin
    int ph, dly, len;
    m_busy = 1'b0; m_rdata = 8'h00; ph = 0; dly = 0; len = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_busy = 1'b0; ph = 0;
      end else begin
        case (ph)
          0: if (m_start) begin dly = $urandom_range(1, 3); ph = 1; end
          1: begin
            dly--;
            if (dly <= 0) begin m_busy = 1'b1; len = $urandom_range(1, 5); ph = 2; end
          end
          2: if (!slave_hold) begin
            len--;
            if (len <= 0) begin
              m_rdata = (slave_q.size() > 0) ? slave_q.pop_front() : 8'($urandom);
              m_busy  = 1'b0;
              ph      = 0;
            end
          end
          default: ph = 0;
        endcase
      end
    end
  end

  // Monitor: checks grants at launch and responses at completion against the queue.
  initial begin
    logic [7:0]         mon_rd [NUM_REQ];
    logic [NUM_REQ-1:0] prev_gnt;
    exp_t               e;
    prev_gnt = '0;
    for (int i = 0; i < NUM_REQ; i++) mon_rd[i] = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        prev_gnt = '0;
        for (int i = 0; i < NUM_REQ; i++) mon_rd[i] = 8'h00;
      end else begin
        check("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
        if (gnt != '0 && prev_gnt == '0) begin
          if (exp_q.size() == 0) begin
            check("launch_unexpected", 64'(gnt), 64'd0);
          end else begin
            e = exp_q[0];
            check("launch_gnt",    64'(gnt),     64'(1) << e.idx);
            check("launch_mstart", 64'(m_start), 64'd1);
            check("launch_busy",   64'(busy),    64'd1);
            check("launch_addr",   64'(m_addr),  64'(e.addr));
            check("launch_rw",     64'(m_rw),    64'(e.rw));
            check("launch_wdata",  64'(m_wdata), 64'(e.wdata));
          end
        end
        if ((done | err) != '0) begin
          if (exp_q.size() == 0) begin
            check("completion_unexpected", 64'({err, done}), 64'd0);
          end else begin
            e = exp_q.pop_front();
            if (e.abort) begin
              check("abort_err",  64'(err),  64'(1) << e.idx);
              check("abort_done", 64'(done), 64'd0);
              check("abort_busy", 64'(busy), 64'd0);
            end else begin
              check("done_vec",  64'(done), 64'(1) << e.idx);
              check("done_err",  64'(err),  64'd0);
              check("done_busy", 64'(busy), 64'd1);
              if (e.rw) mon_rd[e.idx] = e.rbyte;
            end
            check("cmpl_gnt",        64'(gnt),     64'd0);
            check("cmpl_mstart",     64'(m_start), 64'd0);
            check("cmpl_addr_held",  64'(m_addr),  64'(e.addr));
            check("cmpl_wdata_held", 64'(m_wdata), 64'(e.wdata));
            for (int i = 0; i < NUM_REQ; i++) check("cmpl_rdata_slice", 64'(rd_v[i]), 64'(mon_rd[i]));
          end
        end
        prev_gnt = gnt;
      end
    end
  end

  task automatic wait_slave_idle();
    int cyc;
    cyc = 0;
    while (m_busy && cyc < 100) begin @(negedge clk); cyc++; end
    check("slave_idle", 64'(m_busy), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  // Runs round_cnt[i] transactions per requester. Each requester holds req
  // while it has work left; the granted one scrambles its inputs mid-transaction
  // and sometimes drops req.
  task automatic run_round();
    logic [6:0] ca [NUM_REQ][4];
    logic       cr [NUM_REQ][4];
    logic [7:0] cw [NUM_REQ][4];
    int         rem    [NUM_REQ];
    int         nth    [NUM_REQ];
    int         served [NUM_REQ];
    int         total, w, cyc, j;
    exp_t       e;
    total = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int k = 0; k < 4; k++) begin
        ca[i][k] = 7'($urandom); cr[i][k] = 1'($urandom); cw[i][k] = 8'($urandom);
      end
      rem[i] = round_cnt[i]; nth[i] = 0; served[i] = 0; total += round_cnt[i];
    end
    // Reference: each grant goes to the first requester with work left, searching from ptr.
    for (int t = 0; t < total; t++) begin
      w = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        j = (ptr_m + k) % NUM_REQ;
        if (w < 0 && rem[j] > 0) w = j;
      end
      e.idx = w; e.addr = ca[w][nth[w]]; e.rw = cr[w][nth[w]]; e.wdata = cw[w][nth[w]];
      e.rbyte = 8'($urandom); e.abort = 1'b0;
      exp_q.push_back(e);
      slave_q.push_back(e.rbyte);
      rem[w]--; nth[w]++;
      ptr_m = (w + 1) % NUM_REQ;
    end
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (round_cnt[i] > 0) begin
        tb_addr[i] = ca[i][0]; req_rw[i] = cr[i][0]; tb_wdata[i] = cw[i][0]; req[i] = 1'b1;
      end
    end
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 40 * total + 100) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i]) begin
          tb_addr[i] = 7'($urandom); req_rw[i] = 1'($urandom); tb_wdata[i] = 8'($urandom);
          if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
        end
        if (done[i]) begin
          served[i]++;
          if (served[i] < round_cnt[i]) begin
            tb_addr[i] = ca[i][served[i]]; req_rw[i] = cr[i][served[i]];
            tb_wdata[i] = cw[i][served[i]]; req[i] = 1'b1;
          end else begin
            req[i] = 1'b0;
          end
        end
      end
    end
    if (exp_q.size() > 0) begin
      check("round_timeout", 64'(exp_q.size()), 64'd0);
      req = '0; exp_q.delete(); slave_q.delete();
      reset = 1'b1; repeat (2) @(negedge clk); reset = 1'b0;
      ptr_m = 0;
      wait_slave_idle();
    end
    req = '0;
    repeat (3) @(negedge clk);
    check("idle_busy",   64'(busy),    64'd0);
    check("idle_gnt",    64'(gnt),     64'd0);
    check("idle_mstart", 64'(m_start), 64'd0);
  endtask

  initial begin
    exp_t e;
    int   cyc;
    reset = 1'b1; req = '0; req_rw = '0;
    for (int i = 0; i < NUM_REQ; i++) begin tb_addr[i] = 7'h00; tb_wdata[i] = 8'h00; end
    repeat (3) @(negedge clk);
    check("rst_gnt",     64'(gnt),     64'd0);
    check("rst_done",    64'(done),    64'd0);
    check("rst_err",     64'(err),     64'd0);
    check("rst_rdata",   64'(rdata),   64'd0);
    check("rst_busy",    64'(busy),    64'd0);
    check("rst_mstart",  64'(m_start), 64'd0);
    check("rst_maddr",   64'(m_addr),  64'd0);
    check("rst_mrw",     64'(m_rw),    64'd0);
    check("rst_mwdata",  64'(m_wdata), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single requesters, then all four held for two transactions each.
    round_cnt = '{0, 0, 1, 0}; run_round();
    round_cnt = '{0, 1, 0, 0}; run_round();
    round_cnt = '{2, 2, 2, 2}; run_round();
    for (int r = 0; r < 15; r++) begin
      for (int i = 0; i < NUM_REQ; i++) round_cnt[i] = $urandom_range(0, 3);
      run_round();
    end

    // Leave ptr at 3, then reset in WAIT: ptr must restart from requester 0.
    round_cnt = '{0, 0, 1, 0}; run_round();
    @(negedge clk);
    tb_addr[2] = 7'h50; req_rw[2] = 1'b0; tb_wdata[2] = 8'hA5; slave_hold = 1'b1;
    e.idx = 2; e.addr = 7'h50; e.rw = 1'b0; e.wdata = 8'hA5; e.rbyte = 8'h00; e.abort = 1'b0;
    exp_q.push_back(e);
    req[2] = 1'b1;
    cyc = 0;
    while (!m_busy && cyc < 50) begin @(negedge clk); cyc++; end
    check("rstwait_mbusy", 64'(m_busy), 64'd1);
    repeat (3) @(negedge clk);
    check("rstwait_in_wait", 64'({busy, m_start, gnt}), 64'({1'b1, 1'b0, 4'b0100}));
    reset = 1'b1; req = '0; exp_q.delete(); slave_q.delete(); slave_hold = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_gnt",    64'(gnt),     64'd0);
    check("rstmid_done",   64'(done),    64'd0);
    check("rstmid_err",    64'(err),     64'd0);
    check("rstmid_busy",   64'(busy),    64'd0);
    check("rstmid_mstart", 64'(m_start), 64'd0);
    check("rstmid_maddr",  64'(m_addr),  64'd0);
    check("rstmid_mwdata", 64'(m_wdata), 64'd0);
    check("rstmid_rdata",  64'(rdata),   64'd0);
    ptr_m = 0;
    wait_slave_idle();
    round_cnt = '{1, 1, 1, 1}; run_round();

`ifdef I2C_ARB_WDOG_EN
    // Stuck slave: err after WDOG_T cycles from LAUNCH entry, then normal service.
    @(negedge clk);
    tb_addr[1] = 7'h2A; req_rw[1] = 1'b1; tb_wdata[1] = 8'h5A; slave_hold = 1'b1;
    e.idx = 1; e.addr = 7'h2A; e.rw = 1'b1; e.wdata = 8'h5A; e.rbyte = 8'h00; e.abort = 1'b1;
    exp_q.push_back(e);
    req[1] = 1'b1;
    cyc = 0;
    while (!gnt[1] && cyc < 50) begin @(negedge clk); cyc++; end
    check("wdog_gnt", 64'(gnt), 64'b0010);
    req = '0;
    cyc = 0;
    while (err == '0 && cyc < 200) begin @(negedge clk); cyc++; end
    check("wdog_latency", 64'(cyc), 64'(WDOG_T));
    slave_hold = 1'b0;
    ptr_m = 2;
    wait_slave_idle();
    round_cnt = '{1, 1, 1, 1}; run_round();
`endif

    repeat (5) @(negedge clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_master_arbiter.md
Name: i2c_master_arbiter

Overview:
- Shares one i2c_master (single-byte address+data transaction engine) between NUM_REQ independent requesters.
- Arbitrates round-robin, snapshots the winner's command and launches it on the master's start/busy handshake.
- Waits for completion, then returns read data and a done pulse to the winner.
- Sits between firmware/CSR-side requesters and the i2c_master instance.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- WDOG_CYCLES, 2000000, watchdog limit in clk cycles (used only with the optional feature).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester level request.
- req_addr  input  NUM_REQ*7  7-bit slave address; requester i uses bits [i*7+:7].
- req_rw  input  NUM_REQ  1 = read, 0 = write.
- req_wdata  input  NUM_REQ*8  write byte; requester i uses bits [i*8+:8].
- gnt  output  NUM_REQ  one-hot grant, high for the whole transaction.
- done  output  NUM_REQ  one-cycle completion pulse to the granted requester.
- err  output  NUM_REQ  one-cycle abort pulse (optional feature only; tied 0 otherwise).
- rdata  output  NUM_REQ*8  per-requester registered read byte.
- busy  output  1  arbiter not in IDLE.
- m_start  output  1  start request to i2c_master.
- m_addr  output  7  latched slave address.
- m_rw  output  1  latched rw.
- m_wdata  output  8  latched write byte.
- m_busy  input  1  i2c_master busy.
- m_rdata  input  8  i2c_master read byte.

Behaviour:
- Reset (synchronous, active-high): every output is 0, including gnt, done, err, rdata, busy, m_start, m_addr, m_rw and m_wdata. State = IDLE. Round-robin pointer ptr = 0.
- Reset asserted mid-transaction aborts it immediately, with no done or err pulse. m_start drops the cycle after reset is sampled.
- FSM states:
  - IDLE → LAUNCH when |req. The winner is the first set req[k] searching k = ptr, ptr+1, … modulo NUM_REQ.
  - On that IDLE→LAUNCH edge the arbiter registers:
    - gnt[winner] = 1;
    - m_addr, m_rw and m_wdata from the winner's slices;
    - m_start = 1;
    - busy = 1.
  - Latency: req sampled in cycle t produces gnt and m_start visible in cycle t+1.
  - LAUNCH: m_start stays high until m_busy is sampled high. Then m_start = 0 and the FSM goes to WAIT.
  - WAIT: stays until m_busy is sampled low, then goes to DONE.
  - DONE (one cycle):
    - done[winner] = 1;
    - if m_rw = 1, rdata slice[winner] ← m_rdata; otherwise that slice is unchanged;
    - gnt = 0;
    - ptr ← (winner+1) mod NUM_REQ;
    - go to IDLE.
  - busy stays 1 through DONE and clears in IDLE.
- Throughput: back-to-back transactions have at least one IDLE cycle between DONE and the next LAUNCH.
- Handshake rules:
  - The command is snapshotted at grant. Later changes to the requester's inputs are ignored.
  - req dropped during a transaction does not abort it; done still pulses.
  - req still high in the IDLE after done counts as a new request, arbitrated fairly against the others.
  - Non-granted requesters wait with their req held; no request is ever lost.
- Widths:
  - Index width is $clog2(NUM_REQ).
  - Pointer wrap is explicit modulo, so non-power-of-2 NUM_REQ never selects an out-of-range index.
- Simultaneous requests: exactly one grant per transaction, in round-robin order. With all req high, grants cycle 0,1,2,3,0…

Optional Feature:
- Macro: I2C_ARB_WDOG_EN.
- When defined:
  - A counter runs in LAUNCH and WAIT.
  - When it reaches WDOG_CYCLES, the arbiter pulses err[winner] for one cycle instead of done, leaves rdata unchanged, drops m_start and gnt, advances ptr and returns to IDLE.
  - The counter clears on every entry to LAUNCH.
- When undefined: no counter, err is tied 0, and the arbiter can wait indefinitely on m_busy.

Decomposition:
- Package i2c_arb_pkg holds:
  - the state enum (IDLE, LAUNCH, WAIT, DONE);
  - the I2C_ADDR_W = 7 and I2C_DATA_W = 8 constants;
  - the default WDOG_CYCLES.
- Sub-module i2c_rr_picker: combinational. Inputs are req vector and ptr; outputs are winner index and valid. It is reusable by other shared-bus arbiters.

Test Plan:
- Single write: req[2]=1, addr 0x50, rw=0, wdata 0xA5; model m_busy high 3 cycles after m_start, for 40 cycles → m_start at t+1; m_addr=0x50, m_wdata=0xA5; done[2] pulses once; rdata unchanged; ptr=3.
- Single read: req[1], rw=1, model returns m_rdata=0x3C → rdata[15:8]=0x3C after done[1]; the other rdata slices remain 0.
- Fairness: all four req held high for 8 transactions → grant order 0,1,2,3,0,1,2,3, exactly one gnt bit at a time.
- Input change mid-transaction: req_wdata[0] changed from 0x11 to 0x22 during WAIT → m_wdata stays 0x11. Dropping req[0] in WAIT still yields done[0].
- Reset mid-WAIT: assert reset one cycle → all outputs 0 next cycle, no done, next grant starts from requester 0.
- With I2C_ARB_WDOG_EN and WDOG_CYCLES=50, m_busy stuck high → err[winner] pulses 50 cycles after LAUNCH entry, no done; the next request is served normally.
